soc_event_queue: RTL

- Upstream feeder for the fabric-controller event unit's event FIFO port (event_fifo_valid / event_fifo_fulln / event_fifo_data).
- Collects single-cycle event pulses from NB_SOURCES SoC peripheral event lines and counts pending events per source.
- Arbitrates pending sources round-robin and presents one event ID at a time on a valid/fulln handshake.
- Lives in the SoC top next to the fc subsystem. Its outputs connect directly to event_fifo_valid_i / event_fifo_data_i, and it takes event_fifo_fulln_o as back-pressure.

---
 rtl/soc_event_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/soc_event_queue.sv
// Event queue feeding the fc event FIFO: per-source pending counters, round-robin
// arbiter and a one-entry valid/fulln output register. Option: SOC_EVENT_QUEUE_PRIO0_EN.
module soc_event_queue #(
   parameter int NB_SOURCES     = 8,
   parameter int EVENT_ID_WIDTH = 8,
   parameter int CNT_WIDTH      = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NB_SOURCES-1:0]     events_i,
   input  logic                      ovf_clr_i,
   output logic                      event_fifo_valid_o,
   output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
   input  logic                      event_fifo_fulln_i,
   output logic [NB_SOURCES-1:0]     ovf_o,
   output logic                      pending_o
);

   localparam int RR_W = $clog2(NB_SOURCES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   out_state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]      cnt_q [NB_SOURCES];
   logic [RR_W-1:0]           rr_q;
   logic [EVENT_ID_WIDTH-1:0] data_q;
   logic [NB_SOURCES-1:0]     ovf_q;

   logic [RR_W-1:0]           grant;
   logic                      grant_valid;
   logic [RR_W:0]             idx;
   logic                      transfer;
   logic                      load;
   logic                      rr_update;
   logic [RR_W-1:0]           rr_next;
   logic [NB_SOURCES-1:0]     inc;
   logic [NB_SOURCES-1:0]     dec;
   logic [NB_SOURCES-1:0]     cnt_nz;
   logic [NB_SOURCES-1:0]     ovf_set;

   assign transfer = (state_q == FULL) && event_fifo_fulln_i;
   assign load     = (state_q == EMPTY) || transfer;

   // Rotating scan from rr; idx carries one extra bit so the wrap is a single subtract.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_valid = 1'b0;
      grant       = '0;
      idx         = '0;
      for (int k = 0; k < NB_SOURCES; k++) begin
         idx = {1'b0, rr_q} + (RR_W+1)'(k);
         if (idx >= (RR_W+1)'(NB_SOURCES)) begin
            idx = idx - (RR_W+1)'(NB_SOURCES);
         end
         if (!grant_valid && (cnt_q[idx[RR_W-1:0]] != '0)) begin
            grant_valid = 1'b1;
            grant       = idx[RR_W-1:0];
         end
      end
`ifdef SOC_EVENT_QUEUE_PRIO0_EN
      if (cnt_q[0] != '0) begin
         grant_valid = 1'b1;
         grant       = '0;
      end
`endif
   end

`ifdef SOC_EVENT_QUEUE_PRIO0_EN
   assign rr_update = load && grant_valid && (grant != '0);
`else
   assign rr_update = load && grant_valid;
`endif
   assign rr_next = (grant == RR_W'(NB_SOURCES - 1)) ? '0 : grant + 1'b1;

   always_comb begin
      inc     = events_i;
      dec     = '0;
      cnt_nz  = '0;
      ovf_set = '0;
      for (int i = 0; i < NB_SOURCES; i++) begin
         dec[i]     = load && grant_valid && (grant == RR_W'(i));
         cnt_nz[i]  = (cnt_q[i] != '0);
         ovf_set[i] = inc[i] && !dec[i] && (cnt_q[i] == CNT_MAX);
      end
   end

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = grant_valid ? FULL : EMPTY;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q   <= '0;
         data_q <= '0;
      end else if (load && grant_valid) begin
         data_q <= EVENT_ID_WIDTH'(grant);
         if (rr_update) begin
            rr_q <= rr_next;
         end
      end
   end

   // NOTE: the counter array is reset explicitly; stale counts would emit phantom events.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NB_SOURCES; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NB_SOURCES; i++) begin
            if (inc[i] && !dec[i] && (cnt_q[i] != CNT_MAX)) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (dec[i] && !inc[i]) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
      end
   end

   // A set in the same cycle as a clear wins.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf_q <= '0;
      end else begin
         ovf_q <= ovf_set | (ovf_clr_i ? '0 : ovf_q);
      end
   end

   assign event_fifo_valid_o = (state_q == FULL);
   assign event_fifo_data_o  = data_q;
   assign ovf_o              = ovf_q;
   assign pending_o          = event_fifo_valid_o || (|cnt_nz);

endmodule
